// File: rtl/slave_port.sv
// Serial system-bus slave: deserialises ID/offset/write data, acks its own DEV_ID,
// drives a byte-wide backend and serialises read data back to the master.
module slave_port #(
    parameter logic [5:0] DEV_ID     = 6'd0,
    parameter int         RD_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       mode,
    input  logic       wr_bus,
    input  logic       master_valid,
    output logic       slave_ready,
    output logic       ack,
    output logic       rd_bus,
    output logic       slave_valid,
    input  logic       master_ready,
    output logic [9:0] s_addr,
    output logic [7:0] s_wr_data,
    output logic       s_wr_en,
    output logic       s_rd_en,
    input  logic [7:0] s_rd_data,
    input  logic       s_rd_valid
);

    typedef enum logic [2:0] {
        ID_PH, OFFS_PH, WR_PH, WR_COMMIT, RD_FETCH, RD_PH, SKIP
    } state_e;

    localparam int             WW        = $clog2(RD_TIMEOUT + 1);
    localparam logic [WW-1:0]  WAIT_LAST = WW'(RD_TIMEOUT - 1);

    state_e        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          mode_q, mode_d;
    logic [4:0]    id_sr_q, id_sr_d;
    logic [8:0]    offs_sr_q, offs_sr_d;
    logic [9:0]    addr_q, addr_d;
    logic [7:0]    wr_sr_q, wr_sr_d;
    logic [7:0]    rd_sr_q, rd_sr_d;
    logic [WW-1:0] wait_q, wait_d;

    logic ready_raw, ack_c, valid_c, wr_en_c, rd_en_c;
    logic in_beat, id_match;

    assign ready_raw = (state_q == ID_PH) || (state_q == OFFS_PH) || (state_q == WR_PH);
    assign in_beat   = master_valid & slave_ready;
    assign id_match  = ({id_sr_q, wr_bus} == DEV_ID);

    always_comb begin
        // NOTE: every signal gets a default before the case so no path can infer a latch.
        state_d   = state_q;
        cnt_d     = cnt_q;
        mode_d    = mode_q;
        id_sr_d   = id_sr_q;
        offs_sr_d = offs_sr_q;
        addr_d    = addr_q;
        wr_sr_d   = wr_sr_q;
        rd_sr_d   = rd_sr_q;
        wait_d    = wait_q;
        ack_c     = 1'b0;
        valid_c   = 1'b0;
        wr_en_c   = 1'b0;
        rd_en_c   = 1'b0;

        case (state_q)
            ID_PH: if (in_beat) begin
                id_sr_d = {id_sr_q[3:0], wr_bus};
                cnt_d   = cnt_q + 4'd1;
                if (cnt_q == 4'd0) mode_d = mode;
                if (cnt_q == 4'd5) begin
                    cnt_d   = 4'd0;
                    ack_c   = id_match;
                    state_d = id_match ? OFFS_PH : SKIP;
                end
            end
            OFFS_PH: if (in_beat) begin
                offs_sr_d = {offs_sr_q[7:0], wr_bus};
                cnt_d     = cnt_q + 4'd1;
                if (cnt_q == 4'd9) begin
                    addr_d  = {offs_sr_q, wr_bus};
                    cnt_d   = 4'd0;
                    wait_d  = '0;
                    state_d = mode_q ? WR_PH : RD_FETCH;
                end
            end
            WR_PH: if (in_beat) begin
                wr_sr_d = {wr_sr_q[6:0], wr_bus};
                cnt_d   = cnt_q + 4'd1;
                if (cnt_q == 4'd7) begin
                    cnt_d   = 4'd0;
                    state_d = WR_COMMIT;
                end
            end
            WR_COMMIT: begin
                wr_en_c = 1'b1;
                state_d = ID_PH;
            end
            RD_FETCH: begin
                // wait_q is zero only on the entry cycle, so the request is a single pulse
                rd_en_c = (wait_q == '0);
                if (s_rd_valid) begin
                    rd_sr_d = s_rd_data;
                    state_d = RD_PH;
                end else if (wait_q == WAIT_LAST) begin
                    rd_sr_d = 8'hFF;
                    state_d = RD_PH;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            RD_PH: begin
                valid_c = 1'b1;
                if (master_ready) begin
                    rd_sr_d = {rd_sr_q[6:0], 1'b0};
                    cnt_d   = cnt_q + 4'd1;
                    if (cnt_q == 4'd7) begin
                        cnt_d   = 4'd0;
                        state_d = ID_PH;
                    end
                end
            end
            SKIP: if (!master_valid) state_d = ID_PH;
            default: state_d = ID_PH;
        endcase
    end

    // NOTE: non-blocking assignments so all registers sample the same pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ID_PH;
            cnt_q     <= '0;
            mode_q    <= 1'b0;
            id_sr_q   <= '0;
            offs_sr_q <= '0;
            addr_q    <= '0;
            wr_sr_q   <= '0;
            rd_sr_q   <= '0;
            wait_q    <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mode_q    <= mode_d;
            id_sr_q   <= id_sr_d;
            offs_sr_q <= offs_sr_d;
            addr_q    <= addr_d;
            wr_sr_q   <= wr_sr_d;
            rd_sr_q   <= rd_sr_d;
            wait_q    <= wait_d;
        end
    end

    // Combinational outputs are forced low while reset is held.
    assign slave_ready = ready_raw & ~rst;
    assign ack         = ack_c & ~rst;
    assign slave_valid = valid_c & ~rst;
    assign rd_bus      = rd_sr_q[7] & valid_c & ~rst;
    assign s_wr_en     = wr_en_c & ~rst;
    assign s_rd_en     = rd_en_c & ~rst;
    assign s_addr      = addr_q;
    assign s_wr_data   = wr_sr_q;

endmodule
